// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and helpers for the unified-memory arbiter.
// Imported by the arbiter top and its latency counter.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_DM = 2'd2;
  localparam logic [1:0] ST_HALTED  = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Bits needed to hold 0..maxVal, never less than one.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_lat_cnt.sv
// Loadable down-counter that tracks the remaining cycles of a memory access.
// Holds at zero; zero flags the last busy cycle.
module mem_arbiter_lat_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] loadVal,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between fetch and data stages,
// with bounded starvation of fetch and a drain-on-halt path.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  input  logic              halt,
  output logic              drained,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbgState
);

  localparam int LAT_W = cntWidth(MEM_LAT - 1);
  localparam int STV_W = cntWidth(STARVE_MAX);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  logic [1:0]       state;
  logic             owner;
  logic             wrQ;
  logic [STV_W-1:0] starveCnt;
  logic             haltPend;
  logic             busy;
  logic             grantDm;
  logic             grantIf;
  logic             latLoad;
  logic             latDec;
  logic             latZero;

  // Handshake: a requester raises req with its address/data and holds them
  // until its done pulse; req still high in the done cycle is a fresh request.
  always_comb begin
    busy    = (state == ST_BUSY_IF) || (state == ST_BUSY_DM);
    grantDm = (state == ST_IDLE) && !halt && !haltPend && dm_req &&
              ((starveCnt < STV_MAX) || !if_req);
    grantIf = (state == ST_IDLE) && !halt && !haltPend && if_req && !grantDm;
    latLoad = grantDm || grantIf;
    latDec  = busy && !latZero;
  end

  mem_arbiter_lat_cnt #(.W(LAT_W)) u_lat_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (latLoad),
    .dec     (latDec),
    .loadVal (LAT_LOAD),
    .zero    (latZero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      wrQ       <= 1'b0;
      starveCnt <= '0;
      haltPend  <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      mem_wr  <= 1'b0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (halt || haltPend) begin
            state <= ST_HALTED;
          end else if (grantDm) begin
            state     <= ST_BUSY_DM;
            owner     <= OWN_DM;
            wrQ       <= dm_wr;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_en    <= 1'b1;
            mem_wr    <= dm_wr;
            if (!if_req) begin
              starveCnt <= '0;
            end else if (starveCnt != STV_MAX) begin
              starveCnt <= starveCnt + STV_W'(1);
            end
          end else if (grantIf) begin
            state     <= ST_BUSY_IF;
            owner     <= OWN_IF;
            wrQ       <= 1'b0;
            mem_addr  <= if_addr;
            mem_en    <= 1'b1;
            starveCnt <= '0;
          end
        end
        ST_BUSY_IF, ST_BUSY_DM: begin
          if (halt) begin
            haltPend <= 1'b1;
          end
          // Last busy cycle: memory data is valid now, done shows next cycle.
          if (latZero) begin
            if (owner == OWN_DM) begin
              dm_done <= 1'b1;
              if (!wrQ) begin
                dm_rdata <= mem_rdata;
              end
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
            state <= (halt || haltPend) ? ST_HALTED : ST_IDLE;
          end
        end
        default: state <= ST_HALTED;
      endcase
    end
  end

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;
  assign drained  = (state == ST_HALTED);
  assign dbgState = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus a randomized run against a timestamp-based model
// of the arbiter and a simple fixed-latency memory responder.
module tb_mem_arbiter;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int MEM_LAT    = 4;
  localparam int STARVE_MAX = 3;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;
  logic              dm_req;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              dm_stall;
  logic              halt;
  logic              drained;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        dbgState;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .halt(halt), .drained(drained),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] junk(input logic [DATA_W-1:0] avoid);
    logic [DATA_W-1:0] v;
    v = DATA_W'($urandom);
    if (v == avoid) v = ~v;
    return v;
  endfunction

  task automatic applyReset();
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    halt = 1'b0; mem_rdata = '0;
    @(negedge clk);
    checkVal("rst_mem_en", mem_en, 1'b0);
    checkVal("rst_mem_wr", mem_wr, 1'b0);
    checkVal("rst_mem_addr", mem_addr, 16'h0);
    checkVal("rst_if_done", if_done, 1'b0);
    checkVal("rst_dm_done", dm_done, 1'b0);
    checkVal("rst_if_rdata", if_rdata, 16'h0);
    checkVal("rst_dm_rdata", dm_rdata, 16'h0);
    checkVal("rst_drained", drained, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // model / scoreboard state for the random phase
  logic [DATA_W-1:0] memArr [256];
  logic [DATA_W-1:0] exp_q [$];
  int                freeAt, starveRun, expIssue, expDone;
  logic              expOwnDm, expWr, ifDoneNow, dmDoneNow, granted;
  logic [ADDR_W-1:0] expAddr;
  logic [DATA_W-1:0] expWdata, expData;
  logic              expOwn [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  int                ng;

  initial begin
    rst = 1'b1;

    // fetch only
    applyReset();
    if_req = 1'b1; if_addr = 16'h0010;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkVal("t1_mem_en", mem_en, k == 1);
      if (k == 1) checkVal("t1_mem_addr", mem_addr, 16'h0010);
      checkVal("t1_if_done", if_done, k == 5);
      checkVal("t1_if_stall", if_stall, k < 5);
      if (k == 5) begin
        checkVal("t1_if_rdata", if_rdata, 16'hBEEF);
        if_req = 1'b0;
      end
      mem_rdata = (k == 4) ? 16'hBEEF : junk(16'hBEEF);
    end

    // simultaneous fetch and load: data first, fetch right after
    applyReset();
    if_req = 1'b1; if_addr = 16'h0020;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0200;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      checkVal("t2_mem_en", mem_en, (k == 1) || (k == 6));
      if (k == 1) checkVal("t2_mem_addr_dm", mem_addr, 16'h0200);
      if (k == 1) checkVal("t2_mem_wr", mem_wr, 1'b0);
      if (k == 6) checkVal("t2_mem_addr_if", mem_addr, 16'h0020);
      checkVal("t2_dm_done", dm_done, k == 5);
      checkVal("t2_if_done", if_done, k == 10);
      checkVal("t2_if_stall", if_stall, k < 10);
      checkVal("t2_dm_stall", dm_stall, k < 5);
      if (k == 5) begin
        checkVal("t2_dm_rdata", dm_rdata, 16'hA5A5);
        dm_req = 1'b0;
      end
      if (k == 10) begin
        checkVal("t2_if_rdata", if_rdata, 16'h5A5A);
        if_req = 1'b0;
      end
      mem_rdata = (k == 4) ? 16'hA5A5 : (k == 9) ? 16'h5A5A : junk(16'hA5A5);
    end

    // store leaves dm_rdata alone
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0040; dm_wdata = 16'h1234;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkVal("t3_mem_en", mem_en, k == 1);
      checkVal("t3_mem_wr", mem_wr, k == 1);
      if (k == 1) checkVal("t3_mem_addr", mem_addr, 16'h0040);
      if (k == 1) checkVal("t3_mem_wdata", mem_wdata, 16'h1234);
      checkVal("t3_dm_done", dm_done, k == 5);
      if (k == 5) begin
        checkVal("t3_dm_rdata", dm_rdata, 16'hA5A5);
        dm_req = 1'b0; dm_wr = 1'b0;
      end
      mem_rdata = junk(16'hA5A5);
    end

    // starvation bound
    applyReset();
    if_req = 1'b1; if_addr = 16'h0100;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0300;
    ng = 0;
    for (int k = 1; k <= 40 && ng < 6; k++) begin
      @(negedge clk);
      if (mem_en) begin
        checkVal($sformatf("t4_grant%0d_is_dm", ng), mem_addr == 16'h0300, expOwn[ng]);
        ng++;
      end
      mem_rdata = junk(16'h0);
    end
    checkVal("t4_grant_count", ng, 6);

    // halt during a load drains, then nothing more is issued
    applyReset();
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0500;
    if_req = 1'b1; if_addr = 16'h0600;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checkVal("t5_mem_en", mem_en, k == 1);
      checkVal("t5_dm_done", dm_done, k == 5);
      checkVal("t5_drained", drained, k >= 5);
      checkVal("t5_if_done", if_done, 1'b0);
      if (k == 5) begin
        checkVal("t5_dm_rdata", dm_rdata, 16'h0F0F);
        dm_req = 1'b0;
      end
      if (k == 2) halt = 1'b1;
      if (k == 3) halt = 1'b0;
      mem_rdata = (k == 4) ? 16'h0F0F : junk(16'h0F0F);
    end
    if_req = 1'b0;

    // reset in the middle of a fetch aborts it
    applyReset();
    if_req = 1'b1; if_addr = 16'h0700;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) checkVal("t6_mem_en_issue", mem_en, 1'b1);
      mem_rdata = junk(16'h0);
    end
    rst = 1'b0;
    #1;
    checkVal("t6_mem_en_rst", mem_en, 1'b0);
    checkVal("t6_if_done_rst", if_done, 1'b0);
    checkVal("t6_if_stall_rst", if_stall, 1'b1);
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checkVal("t6_if_done_after", if_done, 1'b0);
      checkVal("t6_mem_en_after", mem_en, 1'b0);
      mem_rdata = junk(16'h0);
    end

    // randomized traffic against the timestamp model
    applyReset();
    for (int i = 0; i < 256; i++) memArr[i] = DATA_W'($urandom);
    freeAt = 0; starveRun = 0; expIssue = -100; expDone = -100;
    expOwnDm = 1'b0; expWr = 1'b0; expAddr = '0; expWdata = '0; expData = '0;
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      checkVal("r_mem_en", mem_en, k == expIssue);
      if (k == expIssue) begin
        checkVal("r_mem_wr", mem_wr, expWr);
        if (expWr) checkVal("r_mem_wdata", mem_wdata, expWdata);
      end
      if (k >= expIssue && k < expIssue + MEM_LAT) checkVal("r_mem_addr", mem_addr, expAddr);
      ifDoneNow = (k == expDone) && !expOwnDm;
      dmDoneNow = (k == expDone) && expOwnDm;
      checkVal("r_if_done", if_done, ifDoneNow);
      checkVal("r_dm_done", dm_done, dmDoneNow);
      if ((ifDoneNow || (dmDoneNow && !expWr)) && exp_q.size() > 0) begin
        expData = exp_q.pop_front();
        if (ifDoneNow) checkVal("r_if_rdata", if_rdata, expData);
        else checkVal("r_dm_rdata", dm_rdata, expData);
      end
      checkVal("r_if_stall", if_stall, if_req && !ifDoneNow);
      checkVal("r_dm_stall", dm_stall, dm_req && !dmDoneNow);
      checkVal("r_drained", drained, 1'b0);

      if (!if_req || ifDoneNow) begin
        if_req  = (k < 760) && ($urandom_range(0, 1) == 1);
        if_addr = ADDR_W'($urandom);
      end
      if (!dm_req || dmDoneNow) begin
        dm_req   = (k < 760) && ($urandom_range(0, 1) == 1);
        dm_wr    = ($urandom_range(0, 1) == 1);
        dm_addr  = ADDR_W'($urandom);
        dm_wdata = DATA_W'($urandom);
      end

      // memory responder: data valid only in the last cycle of the access
      if (k == expIssue + MEM_LAT - 1 && !expWr && exp_q.size() > 0) mem_rdata = exp_q[0];
      else mem_rdata = junk(exp_q.size() > 0 ? exp_q[0] : 16'h0);

      granted = 1'b0;
      if (k >= freeAt) begin
        if (dm_req && (starveRun < STARVE_MAX || !if_req)) begin
          expOwnDm = 1'b1; expAddr = dm_addr; expWr = dm_wr; expWdata = dm_wdata;
          starveRun = if_req ? ((starveRun < STARVE_MAX) ? starveRun + 1 : starveRun) : 0;
          granted = 1'b1;
        end else if (if_req) begin
          expOwnDm = 1'b0; expAddr = if_addr; expWr = 1'b0;
          starveRun = 0;
          granted = 1'b1;
        end
      end
      if (granted) begin
        expIssue = k + 1;
        expDone  = k + MEM_LAT + 1;
        freeAt   = expDone;
        if (expWr) memArr[expAddr[7:0]] = expWdata;
        else exp_q.push_back(memArr[expAddr[7:0]]);
      end
    end
    checkVal("r_final_if_stall", if_stall, 1'b0);
    checkVal("r_final_dm_stall", dm_stall, 1'b0);
    checkVal("r_final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
